// File: rtl/raw_data_arbiter.sv
// raw_data_arbiter: packet-granular round-robin sharing of the raw data output FIFO among four sources,
// with flush requests turned into output FIFO clear pulses at packet boundaries.
module raw_data_arbiter #(
  parameter int NUM_SRC = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] src_fifo_empty,
  input  logic [NUM_SRC-1:0] src_last,
  output logic [NUM_SRC-1:0] src_fifo_pop,
  output logic [NUM_SRC-1:0] src_index_pop,
  output logic [NUM_SRC-1:0] src_wstrb_pop,
  input  logic               raw_data_out_fifo_full,
  output logic               raw_data_out_fifo_push,
  input  logic               flush_req,
  output logic               raw_data_out_fifo_clr,
  output logic               raw_data_out_index_clr,
  output logic [1:0]         raw_data_sel,
  output logic               busy
);
  typedef enum logic [1:0] {IDLE, XFER, FLUSH} state_t;
  state_t     state;
  logic [1:0] sel, rr_ptr, grant;
  logic       flush_pend, hit, xfer;
  // descending scan so the source closest to rr_ptr wins
  always_comb begin
    hit = 1'b0;
    grant = rr_ptr;
    for (int i = NUM_SRC - 1; i >= 0; i--)
      if (!src_fifo_empty[rr_ptr + 2'(i)]) begin
        hit = 1'b1;
        grant = rr_ptr + 2'(i);
      end
  end
  assign xfer = state == XFER && !src_fifo_empty[sel] && !raw_data_out_fifo_full;
  assign src_fifo_pop = xfer ? NUM_SRC'(1) << sel : '0;
  assign src_index_pop = src_fifo_pop;
  assign src_wstrb_pop = src_fifo_pop;
  assign raw_data_out_fifo_push = xfer;
  assign raw_data_out_fifo_clr = state == FLUSH;
  assign raw_data_out_index_clr = state == FLUSH;
  assign raw_data_sel = sel;
  assign busy = state != IDLE;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      sel <= '0;
      rr_ptr <= '0;
      flush_pend <= 1'b0;
    end else begin
      // an IDLE cycle with flush_pend always enters FLUSH, which is where the pending flag is consumed
      flush_pend <= flush_req || (flush_pend && state != IDLE);
      case (state)
        IDLE:
          if (flush_pend) state <= FLUSH;
          else if (hit) begin
            sel <= grant;
            state <= XFER;
          end
        XFER:
          if (xfer && src_last[sel]) begin
            rr_ptr <= sel + 2'd1;
            state <= IDLE;
          end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_raw_data_arbiter.sv
// tb_raw_data_arbiter: queue-based packet model of the four sources driving the arbiter, per-scenario checks.
module tb_raw_data_arbiter;
  logic       clk = 0, reset = 0;
  logic [3:0] src_fifo_empty, src_last, src_fifo_pop, src_index_pop, src_wstrb_pop;
  logic       raw_data_out_fifo_full, raw_data_out_fifo_push, flush_req;
  logic       raw_data_out_fifo_clr, raw_data_out_index_clr, busy;
  logic [1:0] raw_data_sel;

  raw_data_arbiter dut (
    .clk(clk), .reset(reset),
    .src_fifo_empty(src_fifo_empty), .src_last(src_last),
    .src_fifo_pop(src_fifo_pop), .src_index_pop(src_index_pop), .src_wstrb_pop(src_wstrb_pop),
    .raw_data_out_fifo_full(raw_data_out_fifo_full), .raw_data_out_fifo_push(raw_data_out_fifo_push),
    .flush_req(flush_req), .raw_data_out_fifo_clr(raw_data_out_fifo_clr),
    .raw_data_out_index_clr(raw_data_out_index_clr), .raw_data_sel(raw_data_sel), .busy(busy)
  );

  always #5 clk = ~clk;

  // each source is a queue of words, value = "this word ends its packet"
  bit         q[4][$];
  bit   [3:0] hide;
  int         owner, m_sel, m_ptr, cyc, vectors, miscompares;
  bit         m_pend, m_flush;
  // {fifo_pop, index_pop, wstrb_pop, push, fifo_clr, index_clr, sel, busy}
  logic [17:0] obs, exp_v;

  function automatic void load(int s, int n);
    for (int i = 0; i < n; i++) q[s].push_back(i == n - 1);
  endfunction

  function automatic bit model_done();
    bit d = owner < 0 && !m_flush && !m_pend;
    for (int s = 0; s < 4; s++) if (q[s].size() != 0) d = 0;
    return d;
  endfunction

  function automatic void model_reset();
    owner = -1; m_sel = 0; m_ptr = 0; m_pend = 0; m_flush = 0;
  endfunction

  // one cycle, starting and ending at a falling edge: drive, sample, predict, advance the model
  task automatic tick(input bit f, input bit fr);
    bit xf;
    logic [3:0] ep;
    for (int s = 0; s < 4; s++) begin
      src_fifo_empty[s] = q[s].size() == 0 || hide[s];
      src_last[s] = q[s].size() > 0 ? q[s][0] : 1'($urandom);
    end
    raw_data_out_fifo_full = f;
    flush_req = fr;
    #1;
    xf = owner >= 0 && !src_fifo_empty[owner] && !f;
    ep = xf ? 4'(1 << owner) : 4'b0;
    exp_v = {ep, ep, ep, xf, m_flush, m_flush, 2'(m_sel), owner >= 0 || m_flush};
    obs = {src_fifo_pop, src_index_pop, src_wstrb_pop, raw_data_out_fifo_push,
           raw_data_out_fifo_clr, raw_data_out_index_clr, raw_data_sel, busy};
    @(posedge clk);
    cyc++;
    if (m_flush) m_flush = 0;
    else if (owner >= 0) begin
      if (xf && q[owner].pop_front()) begin
        m_ptr = (owner + 1) % 4;
        owner = -1;
      end
    end else if (m_pend) begin
      m_flush = 1;
      m_pend = 0;
    end else
      for (int k = 0; k < 4; k++)
        if (!src_fifo_empty[(m_ptr + k) % 4]) begin
          owner = (m_ptr + k) % 4;
          m_sel = owner;
          break;
        end
    m_pend |= fr;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 0;
    hide = 0;
    raw_data_out_fifo_full = 0;
    flush_req = 0;
    src_fifo_empty = '1;
    src_last = '0;
    for (int s = 0; s < 4; s++) q[s].delete();
    repeat (2) @(negedge clk);
    model_reset();
    reset = 1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    for (int s = 0; s < 4; s++) load(s, 2);
    hide = 0;
    src_fifo_empty = '0;
    src_last = '1;
    raw_data_out_fifo_full = 0;
    flush_req = 0;
    for (int i = 0; i < 2; i++) begin
      #1;
      if ({src_fifo_pop, src_index_pop, src_wstrb_pop, raw_data_out_fifo_push, raw_data_out_fifo_clr,
           raw_data_out_index_clr, raw_data_sel, busy} !== 18'd0) begin
        miscompares++;
        $display("FAIL reset_outputs got %h exp 0", {src_fifo_pop, src_index_pop, src_wstrb_pop,
                 raw_data_out_fifo_push, raw_data_out_fifo_clr, raw_data_out_index_clr, raw_data_sel, busy});
      end
      vectors++;
      @(negedge clk);
    end
    model_reset();
    reset = 1;
    for (int i = 0; i < 60 && !model_done(); i++) begin
      tick(0, 0);
      if (obs !== exp_v) begin miscompares++; $display("FAIL reset_seq cyc %0d got %h exp %h", cyc, obs, exp_v); end
      vectors++;
      if (i == 1 && (obs[2:1] !== 2'd0 || obs[5] !== 1'b1)) begin
        miscompares++;
        $display("FAIL reset_first_grant sel %0d push %b exp sel 0 push 1", obs[2:1], obs[5]);
      end
      if (i == 1) vectors++;
    end
    if (!model_done()) begin miscompares++; $display("FAIL reset_drain timeout"); end
    vectors++;
  endtask

  task automatic test_round_robin();
    int got[$];
    do_reset();
    for (int s = 0; s < 4; s++) load(s, 2);
    load(0, 2);
    for (int i = 0; i < 40 && !model_done(); i++) begin
      tick(0, 0);
      if (obs !== exp_v) begin miscompares++; $display("FAIL rr cyc %0d got %h exp %h", cyc, obs, exp_v); end
      vectors++;
      if (obs[5]) got.push_back(int'(obs[2:1]));
    end
    if (got.size() != 10) begin miscompares++; $display("FAIL rr_push_count got %0d exp 10", got.size()); end
    vectors++;
    foreach (got[i]) begin
      if (got[i] != (i / 2) % 4) begin miscompares++; $display("FAIL rr_order push %0d sel %0d exp %0d", i, got[i], (i / 2) % 4); end
      vectors++;
    end
  endtask

  task automatic test_backpressure();
    bit seen = 0;
    int pushes = 0;
    do_reset();
    load(2, 4);
    for (int i = 0; i < 6 && !seen; i++) begin
      tick(0, 0);
      if (obs !== exp_v) begin miscompares++; $display("FAIL bp_start cyc %0d got %h exp %h", cyc, obs, exp_v); end
      vectors++;
      seen = obs[5];
    end
    pushes = int'(seen);
    for (int i = 0; i < 5; i++) begin
      tick(1, 0);
      if (obs[17:5] !== 13'd0) begin miscompares++; $display("FAIL bp_stall cyc %0d strobes %h exp 0", cyc, obs[17:5]); end
      vectors++;
    end
    for (int i = 0; i < 20 && !model_done(); i++) begin
      tick(0, 0);
      if (obs !== exp_v) begin miscompares++; $display("FAIL bp cyc %0d got %h exp %h", cyc, obs, exp_v); end
      if (obs[17:14] !== obs[13:10] || obs[17:14] !== obs[9:6]) begin
        miscompares++;
        $display("FAIL bp_pop_equal cyc %0d pops %h %h %h", cyc, obs[17:14], obs[13:10], obs[9:6]);
      end
      vectors += 2;
      pushes += int'(obs[5]);
    end
    if (pushes != 4) begin miscompares++; $display("FAIL bp_pushes got %0d exp 4", pushes); end
    vectors++;
  endtask

  task automatic test_starved();
    bit seen = 0;
    int got[$];
    do_reset();
    load(1, 3);
    load(3, 1);
    for (int i = 0; i < 6 && !seen; i++) begin
      tick(0, 0);
      if (obs !== exp_v) begin miscompares++; $display("FAIL starve_start cyc %0d got %h exp %h", cyc, obs, exp_v); end
      vectors++;
      seen = obs[5];
    end
    if (!seen || obs[2:1] !== 2'd1) begin miscompares++; $display("FAIL starve_first seen %b sel %0d exp sel 1", seen, obs[2:1]); end
    vectors++;
    hide[1] = 1;
    for (int i = 0; i < 3; i++) begin
      tick(0, 0);
      if (obs[2:1] !== 2'd1 || obs[5] !== 1'b0 || obs[0] !== 1'b1) begin
        miscompares++;
        $display("FAIL starve_hold cyc %0d sel %0d push %b busy %b exp 1 0 1", cyc, obs[2:1], obs[5], obs[0]);
      end
      vectors++;
    end
    hide = 0;
    for (int i = 0; i < 20 && !model_done(); i++) begin
      tick(0, 0);
      if (obs !== exp_v) begin miscompares++; $display("FAIL starve cyc %0d got %h exp %h", cyc, obs, exp_v); end
      vectors++;
      if (obs[5]) got.push_back(int'(obs[2:1]));
    end
    if (got.size() != 3 || got[0] != 1 || got[1] != 1 || got[2] != 3) begin
      miscompares++;
      $display("FAIL starve_order got %p exp '{1,1,3}", got);
    end
    vectors++;
  endtask

  task automatic test_flush();
    bit seen = 0;
    int last0 = -1, push2 = -1;
    int clr[$], cl[$];
    do_reset();
    load(0, 4);
    load(2, 1);
    for (int i = 0; i < 6 && !seen; i++) begin
      tick(0, 0);
      if (obs !== exp_v) begin miscompares++; $display("FAIL flush_start cyc %0d got %h exp %h", cyc, obs, exp_v); end
      vectors++;
      seen = obs[5];
    end
    for (int i = 0; i < 30 && !model_done(); i++) begin
      tick(0, i == 0);
      if (obs !== exp_v) begin miscompares++; $display("FAIL flush cyc %0d got %h exp %h", cyc, obs, exp_v); end
      vectors++;
      if (obs[5] && obs[2:1] == 2'd0) last0 = cyc;
      if (obs[5] && obs[2:1] == 2'd2) push2 = cyc;
      if (obs[4]) clr.push_back(cyc);
    end
    if (clr.size() != 1 || clr[0] != last0 + 2 || push2 <= clr[0]) begin
      miscompares++;
      $display("FAIL flush_timing clr %p last %0d push2 %0d exp one clr at last+2 before push2", clr, last0, push2);
    end
    vectors++;
    for (int k = 0; k < 8; k++) begin
      tick(0, k == 0 || k == 2);
      if (obs !== exp_v) begin miscompares++; $display("FAIL flush2 cyc %0d got %h exp %h", cyc, obs, exp_v); end
      vectors++;
      if (obs[4]) cl.push_back(k);
    end
    if (cl.size() != 2 || cl[0] != 2 || cl[1] != 4) begin
      miscompares++;
      $display("FAIL flush_double clr cycles %p exp '{2,4}", cl);
    end
    vectors++;
  endtask

  task automatic test_async_reset();
    bit seen = 0;
    do_reset();
    load(1, 1);
    load(2, 4);
    for (int i = 0; i < 12 && !seen; i++) begin
      tick(0, 0);
      if (obs !== exp_v) begin miscompares++; $display("FAIL ar_start cyc %0d got %h exp %h", cyc, obs, exp_v); end
      vectors++;
      seen = obs[5] && obs[2:1] == 2'd2;
    end
    if (!seen) begin miscompares++; $display("FAIL ar_no_xfer_on_src2"); end
    vectors++;
    #2 reset = 0;
    #1;
    if ({src_fifo_pop, src_index_pop, src_wstrb_pop, raw_data_out_fifo_push, raw_data_sel, busy} !== 16'd0) begin
      miscompares++;
      $display("FAIL ar_drop got %h exp 0", {src_fifo_pop, src_index_pop, src_wstrb_pop, raw_data_out_fifo_push, raw_data_sel, busy});
    end
    vectors++;
    @(negedge clk);
    model_reset();
    reset = 1;
    load(0, 1);
    load(3, 1);
    for (int i = 0; i < 40 && !model_done(); i++) begin
      tick(0, 0);
      if (obs !== exp_v) begin miscompares++; $display("FAIL ar cyc %0d got %h exp %h", cyc, obs, exp_v); end
      vectors++;
      if (i == 1 && (obs[2:1] !== 2'd0 || obs[5] !== 1'b1)) begin
        miscompares++;
        $display("FAIL ar_regrant sel %0d push %b exp sel 0 push 1", obs[2:1], obs[5]);
      end
      if (i == 1) vectors++;
    end
    if (!model_done()) begin miscompares++; $display("FAIL ar_drain timeout"); end
    vectors++;
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        int s = $urandom_range(0, 3);
        if (q[s].size() < 12) load(s, $urandom_range(1, 4));
      end
      for (int s = 0; s < 4; s++) hide[s] = $urandom_range(0, 9) == 0;
      tick($urandom_range(0, 3) == 0, $urandom_range(0, 24) == 0);
      if (obs !== exp_v) begin miscompares++; $display("FAIL rand cyc %0d got %h exp %h", cyc, obs, exp_v); end
      vectors++;
    end
    hide = 0;
    for (int i = 0; i < 300 && !model_done(); i++) begin
      tick(0, 0);
      if (obs !== exp_v) begin miscompares++; $display("FAIL rand_drain cyc %0d got %h exp %h", cyc, obs, exp_v); end
      vectors++;
    end
    if (!model_done()) begin miscompares++; $display("FAIL rand_drain timeout"); end
    vectors++;
  endtask

  initial begin
    hide = 0;
    model_reset();
    test_reset();
    test_round_robin();
    test_backpressure();
    test_starved();
    test_flush();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
endmodule
